// File: rtl/vadduxm_seq_if.sv
// rtl/vadduxm_seq_if.sv - operand request and result handshake bundle for vadduxm_seq
interface vadduxm_seq_if #(
    parameter int BEATS = 4
);
    localparam int VW = 32 * BEATS;

    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] vra;
    logic [VW-1:0] vrb;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] vrt;
    logic          ovf;

    modport master (
        output in_valid, vra, vrb, mode, out_ready,
        input  in_ready, out_valid, vrt, ovf
    );

    modport slave (
        input  in_valid, vra, vrb, mode, out_ready,
        output in_ready, out_valid, vrt, ovf
    );
endinterface

// File: rtl/vadduxm_seq.sv
// rtl/vadduxm_seq.sv - sequential lane-partitioned unsigned modulo vector add, 32 bits per beat
module vadduxm_seq #(
    parameter int BEATS = 4
) (
    input  logic          clk,
    input  logic          rst,
    vadduxm_seq_if.slave  bus
);
    localparam int VW = 32 * BEATS;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [VW-1:0] a_q, b_q;
    logic [1:0]    mode_q;
    logic [VW-1:0] vrt_q, vrt_d;
    logic          ovf_q, ovf_d;
    logic          capture;

    logic [31:0]   slice_a, slice_b;
    logic [31:0]   byte_sum, half_sum, word_sum;
    logic [3:0]    byte_cy;
    logic [1:0]    half_cy;
    logic          word_cy;
    logic [31:0]   lane_sum;
    logic          lane_cy;

    assign slice_a = a_q[32*beat_q +: 32];
    assign slice_b = b_q[32*beat_q +: 32];

    // All three partitions are computed in parallel; the captured mode picks one.
    always_comb begin
        byte_sum = '0;
        byte_cy  = '0;
        half_sum = '0;
        half_cy  = '0;
        for (int i = 0; i < 4; i++) begin
            {byte_cy[i], byte_sum[8*i +: 8]} =
                {1'b0, slice_a[8*i +: 8]} + {1'b0, slice_b[8*i +: 8]};
        end
        for (int i = 0; i < 2; i++) begin
            {half_cy[i], half_sum[16*i +: 16]} =
                {1'b0, slice_a[16*i +: 16]} + {1'b0, slice_b[16*i +: 16]};
        end
        {word_cy, word_sum} = {1'b0, slice_a} + {1'b0, slice_b};
    end

    // Reserved mode 2'b11 falls into the byte partition.
    always_comb begin
        lane_sum = byte_sum;
        lane_cy  = |byte_cy;
        case (mode_q)
            2'b01: begin
                lane_sum = half_sum;
                lane_cy  = |half_cy;
            end
            2'b10: begin
                lane_sum = word_sum;
                lane_cy  = word_cy;
            end
            default: begin
                lane_sum = byte_sum;
                lane_cy  = |byte_cy;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        vrt_d   = vrt_q;
        ovf_d   = ovf_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    capture = 1'b1;
                    ovf_d   = 1'b0;
                    beat_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                vrt_d[32*beat_q +: 32] = lane_sum;
                ovf_d = ovf_q | lane_cy;
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            vrt_q   <= '0;
            ovf_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            vrt_q   <= vrt_d;
            ovf_q   <= ovf_d;
            if (capture) begin
                a_q    <= bus.vra;
                b_q    <= bus.vrb;
                mode_q <= bus.mode;
            end
        end
    end

    // rst gates in_ready directly so no request is taken during reset.
    assign bus.in_ready  = (state_q == IDLE) & ~rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.vrt       = vrt_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_vadduxm_seq.sv
// tb/tb_vadduxm_seq.sv - scoreboard bench for vadduxm_seq with lane-arithmetic reference model
module tb_vadduxm_seq;
    localparam int BEATS = 4;
    localparam int VW    = 32 * BEATS;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  m;
        logic [31:0] r;
        logic        c;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [VW:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vadduxm_seq_if #(.BEATS(BEATS)) bus ();
    vadduxm_seq #(.BEATS(BEATS)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string name, input logic [VW:0] act, input logic [VW:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Element-wise (a + b) mod 2^L, ovf = any element sum reaching 2^L.
    function automatic logic [VW:0] model(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                          input logic [1:0] m);
        int              lw;
        logic [VW-1:0]   r;
        logic            c;
        logic [VW-1:0]   ta, tb;
        longint unsigned x, y, s, mask;
        lw   = (m == 2'b01) ? 16 : (m == 2'b10) ? 32 : 8;
        mask = (64'd1 << lw) - 1;
        r    = '0;
        c    = 1'b0;
        for (int e = 0; e < VW / lw; e++) begin
            ta = a >> (e * lw);
            tb = b >> (e * lw);
            x  = longint'(ta[31:0]) & mask;
            y  = longint'(tb[31:0]) & mask;
            s  = x + y;
            if (s > mask) c = 1'b1;
            r  = r | (VW'(s & mask) << (e * lw));
        end
        return {c, r};
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < BEATS; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Monitor: pops on every result handshake, sampling 2 time units before the edge.
    initial begin
        logic [VW:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && bus.in_ready && bus.out_valid) begin
                n_cmp++;
                n_err++;
                $display("FAIL ready_valid_overlap: in_ready=1 out_valid=1 required not both");
            end
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_result: got %h expected no result", {bus.ovf, bus.vrt});
                end else begin
                    e = exp_q.pop_front();
                    check("result", {bus.ovf, bus.vrt}, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic issue(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [1:0] m,
                         input logic [VW:0] exp, output int acc);
        int w;
        bus.vra      = a;
        bus.vrb      = b;
        bus.mode     = m;
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready=0 required 1");
        end
        exp_q.push_back(exp);
        acc = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.vra      = rand_vec();
        bus.vrb      = rand_vec();
        bus.mode     = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_valid(input int acc, output int lat);
        int w;
        w = 0;
        while (!bus.out_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        lat = cyc - acc - 1;
        if (!bus.out_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL valid_timeout: out_valid=0 required 1");
        end
    endtask

    task automatic run_op(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [1:0] m,
                          input logic [VW:0] exp);
        int acc, lat;
        bus.out_ready = 1'b1;
        issue(a, b, m, exp, acc);
        wait_valid(acc, lat);
        check("latency", VW'(lat), VW'(BEATS));
        @(negedge clk);
        check("in_ready_after_hs", bus.in_ready, 1);
        check("out_valid_after_hs", bus.out_valid, 0);
    endtask

    initial begin
        vec_t        vt[$];
        logic [VW:0] e;
        logic [VW-1:0] a, b;
        logic [1:0]  m;
        int          acc, lat, w;
        bit          done;
        int          accs[$];

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.vra       = '0;
        bus.vrb       = '0;
        bus.mode      = 2'b00;

        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_vrt_ovf", {bus.ovf, bus.vrt}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1);

        vt.push_back('{32'hFF80_7F01, 32'h0180_0101, 2'b00, 32'h0000_8002, 1'b1});
        vt.push_back('{32'hFF80_7F01, 32'h0180_0101, 2'b01, 32'h0100_8002, 1'b1});
        vt.push_back('{32'hFF80_7F01, 32'h0180_0101, 2'b10, 32'h0100_8002, 1'b1});
        vt.push_back('{32'hFF80_7F01, 32'h0180_0101, 2'b11, 32'h0000_8002, 1'b1});
        for (int i = 0; i < 4; i++)
            vt.push_back('{32'h1111_1111, 32'h2222_2222, 2'(i), 32'h3333_3333, 1'b0});
        vt.push_back('{32'h00FF_00FF, 32'h0001_0001, 2'b00, 32'h0000_0000, 1'b1});
        vt.push_back('{32'h00FF_00FF, 32'h0001_0001, 2'b01, 32'h0100_0100, 1'b0});
        vt.push_back('{32'h00FF_00FF, 32'h0001_0001, 2'b10, 32'h0100_0100, 1'b0});
        vt.push_back('{32'h00FF_00FF, 32'h0001_0001, 2'b11, 32'h0000_0000, 1'b1});
        foreach (vt[i])
            run_op({BEATS{vt[i].a}}, {BEATS{vt[i].b}}, vt[i].m, {vt[i].c, {BEATS{vt[i].r}}});

        // Random operands, random consumer backpressure.
        for (int n = 0; n < 30; n++) begin
            a = rand_vec();
            b = rand_vec();
            m = 2'($urandom_range(0, 3));
            bus.out_ready = 1'($urandom_range(0, 1));
            issue(a, b, m, model(a, b, m), acc);
            done = 1'b0;
            w = 0;
            while (!done && w < 100) begin
                if (bus.out_valid && bus.out_ready) done = 1'b1;
                @(negedge clk);
                w++;
                if (!done) bus.out_ready = 1'($urandom_range(0, 1));
            end
            if (!done) begin
                n_cmp++;
                n_err++;
                $display("FAIL random_handshake_timeout: out_valid=%0b required handshake", bus.out_valid);
            end
        end

        // Held result under backpressure with noisy inputs.
        a = rand_vec();
        b = rand_vec();
        m = 2'($urandom_range(0, 3));
        e = model(a, b, m);
        bus.out_ready = 1'b0;
        issue(a, b, m, e, acc);
        wait_valid(acc, lat);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_held", {bus.ovf, bus.vrt}, e);
            check("bp_in_ready", bus.in_ready, 0);
            bus.vra      = rand_vec();
            bus.vrb      = rand_vec();
            bus.in_valid = 1'(i % 2);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", bus.in_ready, 1);

        // Reset after slice 2 has been written.
        a = rand_vec();
        b = rand_vec();
        issue(a, b, 2'b00, model(a, b, 2'b00), acc);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_vrt_ovf", {bus.ovf, bus.vrt}, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        void'(exp_q.pop_back());
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);
        for (int i = 0; i < BEATS + 2; i++) begin
            check("post_rst_no_valid", bus.out_valid, 0);
            @(negedge clk);
        end
        a = rand_vec();
        b = rand_vec();
        run_op(a, b, 2'b01, model(a, b, 2'b01));

        // Back-to-back requests with in_valid and out_ready held high.
        bus.out_ready = 1'b1;
        bus.vra       = rand_vec();
        bus.vrb       = rand_vec();
        bus.mode      = 2'($urandom_range(0, 3));
        bus.in_valid  = 1'b1;
        w = 0;
        while (accs.size() < 3 && w < 60) begin
            done = bus.in_ready;
            if (done) begin
                exp_q.push_back(model(bus.vra, bus.vrb, bus.mode));
                accs.push_back(cyc);
            end
            @(negedge clk);
            w++;
            if (done) begin
                bus.vra  = rand_vec();
                bus.vrb  = rand_vec();
                bus.mode = 2'($urandom_range(0, 3));
            end
        end
        bus.in_valid = 1'b0;
        if (accs.size() == 3) begin
            check("b2b_spacing_1", VW'(accs[1] - accs[0]), VW'(BEATS + 2));
            check("b2b_spacing_2", VW'(accs[2] - accs[1]), VW'(BEATS + 2));
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL b2b_accepts: got %0d expected 3", accs.size());
        end
        w = 0;
        while (exp_q.size() != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        check("scoreboard_drained", VW'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
